// File: rtl/traffic_lights_multi.sv
// traffic_lights_multi: round-robin multi-approach intersection controller.
// Serves NUM_DIR signal heads in turn with an all-red clearance between
// approaches; supports OFF (dark) and FREE (yellow blink) modes and
// per-approach programmable green/yellow times plus a global clearance time.
module traffic_lights_multi #(
   parameter int NUM_DIR        = 2,
   parameter int CLK_PER_MS     = 2,
   parameter int TIME_W         = 16,
   parameter int RED_YEL_MS     = 50,
   parameter int GREEN_BLINK_MS = 50,
   parameter int BLINK_HALF_MS  = 5,
   parameter int DEF_GREEN_MS   = 500,
   parameter int DEF_YELLOW_MS  = 100,
   parameter int DEF_CLEAR_MS   = 20
) (
   input  logic                       clk_i,
   input  logic                       srst_i,
   input  logic                       cmd_valid_i,
   input  logic [2:0]                 cmd_type_i,
   input  logic [$clog2(NUM_DIR)-1:0] cmd_dir_i,
   input  logic [TIME_W-1:0]          cmd_data_i,
   output logic [NUM_DIR-1:0]         red_o,
   output logic [NUM_DIR-1:0]         yellow_o,
   output logic [NUM_DIR-1:0]         green_o,
   output logic [$clog2(NUM_DIR)-1:0] active_dir_o
);

   localparam int DIR_W   = $clog2(NUM_DIR);
   localparam int CNT_W   = TIME_W + $clog2(CLK_PER_MS) + 1;
   localparam int BLK_CYC = BLINK_HALF_MS * CLK_PER_MS;
   localparam int BLK_W   = (BLK_CYC > 1) ? $clog2(BLK_CYC) : 1;

   localparam logic [2:0] CMD_NORMAL = 3'd0;
   localparam logic [2:0] CMD_OFF    = 3'd1;
   localparam logic [2:0] CMD_FREE   = 3'd2;
   localparam logic [2:0] CMD_GREEN  = 3'd3;
   localparam logic [2:0] CMD_CLEAR  = 3'd4;
   localparam logic [2:0] CMD_YELLOW = 3'd5;

   typedef enum logic [2:0] {
      S_ALL_RED,
      S_RED_YEL,
      S_GREEN,
      S_GREEN_BLINK,
      S_YELLOW,
      S_BLINK_ALL,
      S_DARK
   } state_t;

   // Converts a programmed time in ms into the terminal counter value;
   // a programmed 0 is served as 1 ms.
   function automatic logic [CNT_W-1:0] f_last_cycle(input logic [TIME_W-1:0] ms);
      logic [CNT_W-1:0] t;
      t = (ms == '0) ? CNT_W'(1) : CNT_W'(ms);
      return (t * CNT_W'(CLK_PER_MS)) - CNT_W'(1);
   endfunction

   state_t             r_state;
   state_t             w_state_nxt;
   logic [DIR_W-1:0]   r_dir;
   logic [DIR_W-1:0]   w_dir_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   r_limit;
   logic [CNT_W-1:0]   w_limit_nxt;
   logic               w_enter;
   logic               w_timed;
   logic [TIME_W-1:0]  r_green  [NUM_DIR];
   logic [TIME_W-1:0]  r_yellow [NUM_DIR];
   logic [TIME_W-1:0]  r_clear;
   logic [TIME_W-1:0]  w_green_sel;
   logic [TIME_W-1:0]  w_yellow_sel;
   logic               r_phase;
   logic [BLK_W-1:0]   r_bcnt;

   assign w_timed = (r_state != S_BLINK_ALL) && (r_state != S_DARK);

   // Next state: timed sequence first, then mode commands override it.
   always_comb begin
      w_state_nxt = r_state;
      w_dir_nxt   = r_dir;
      w_enter     = 1'b0;
      if (w_timed && (r_cnt == r_limit)) begin
         w_enter = 1'b1;
         case (r_state)
            S_ALL_RED:     w_state_nxt = S_RED_YEL;
            S_RED_YEL:     w_state_nxt = S_GREEN;
            S_GREEN:       w_state_nxt = S_GREEN_BLINK;
            S_GREEN_BLINK: w_state_nxt = S_YELLOW;
            default: begin
               w_state_nxt = S_ALL_RED;
               w_dir_nxt   = (r_dir == DIR_W'(NUM_DIR - 1)) ? '0 : r_dir + DIR_W'(1);
            end
         endcase
      end
      if (cmd_valid_i) begin
         if (cmd_type_i == CMD_OFF && r_state != S_DARK) begin
            w_state_nxt = S_DARK;
            w_dir_nxt   = r_dir;
            w_enter     = 1'b1;
         end else if (cmd_type_i == CMD_FREE && r_state != S_BLINK_ALL) begin
            w_state_nxt = S_BLINK_ALL;
            w_dir_nxt   = r_dir;
            w_enter     = 1'b1;
         end else if (cmd_type_i == CMD_NORMAL && !w_timed) begin
            w_state_nxt = S_ALL_RED;
            w_dir_nxt   = '0;
            w_enter     = 1'b1;
         end
      end
   end

   // Duration of the state being entered, from the times held before this edge.
   always_comb begin
      w_green_sel  = '0;
      w_yellow_sel = '0;
      for (int unsigned d = 0; d < NUM_DIR; d++) begin
         if (w_dir_nxt == DIR_W'(d)) begin
            w_green_sel  = r_green[d];
            w_yellow_sel = r_yellow[d];
         end
      end
      case (w_state_nxt)
         S_ALL_RED:     w_limit_nxt = f_last_cycle(r_clear);
         S_RED_YEL:     w_limit_nxt = f_last_cycle(TIME_W'(RED_YEL_MS));
         S_GREEN:       w_limit_nxt = f_last_cycle(w_green_sel);
         S_GREEN_BLINK: w_limit_nxt = f_last_cycle(TIME_W'(GREEN_BLINK_MS));
         S_YELLOW:      w_limit_nxt = f_last_cycle(w_yellow_sel);
         default:       w_limit_nxt = '0;
      endcase
   end

   // State, approach, duration counter and blink phase registers.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_state <= S_ALL_RED;
         r_dir   <= '0;
         r_cnt   <= '0;
         r_limit <= f_last_cycle(TIME_W'(DEF_CLEAR_MS));
         r_phase <= 1'b1;
         r_bcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_dir   <= w_dir_nxt;
         if (w_enter) begin
            r_cnt   <= '0;
            r_limit <= w_limit_nxt;
         end else if (w_timed) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_enter && (w_state_nxt == S_GREEN_BLINK || w_state_nxt == S_BLINK_ALL)) begin
            r_phase <= 1'b1;
            r_bcnt  <= '0;
         end else if (!w_enter && (r_state == S_GREEN_BLINK || r_state == S_BLINK_ALL)) begin
            if (r_bcnt == BLK_W'(BLK_CYC - 1)) begin
               r_bcnt  <= '0;
               r_phase <= ~r_phase;
            end else begin
               r_bcnt <= r_bcnt + BLK_W'(1);
            end
         end
      end
   end

   // Programmable time registers, written by commands 3/4/5.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         for (int unsigned d = 0; d < NUM_DIR; d++) begin
            r_green[d]  <= TIME_W'(DEF_GREEN_MS);
            r_yellow[d] <= TIME_W'(DEF_YELLOW_MS);
         end
         r_clear <= TIME_W'(DEF_CLEAR_MS);
      end else if (cmd_valid_i) begin
         if (cmd_type_i == CMD_CLEAR) begin
            r_clear <= cmd_data_i;
         end
         for (int unsigned d = 0; d < NUM_DIR; d++) begin
            if (cmd_dir_i == DIR_W'(d)) begin
               if (cmd_type_i == CMD_GREEN)  r_green[d]  <= cmd_data_i;
               if (cmd_type_i == CMD_YELLOW) r_yellow[d] <= cmd_data_i;
            end
         end
      end
   end

   // Lamp decode from registered state: non-active approaches show red.
   always_comb begin
      red_o    = '0;
      yellow_o = '0;
      green_o  = '0;
      case (r_state)
         S_DARK: ;
         S_BLINK_ALL: yellow_o = {NUM_DIR{r_phase}};
         default: begin
            red_o = '1;
            for (int unsigned d = 0; d < NUM_DIR; d++) begin
               if (r_dir == DIR_W'(d)) begin
                  case (r_state)
                     S_RED_YEL:     yellow_o[d] = 1'b1;
                     S_GREEN: begin
                        red_o[d]   = 1'b0;
                        green_o[d] = 1'b1;
                     end
                     S_GREEN_BLINK: begin
                        red_o[d]   = 1'b0;
                        green_o[d] = r_phase;
                     end
                     S_YELLOW: begin
                        red_o[d]    = 1'b0;
                        yellow_o[d] = 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
         end
      endcase
   end

   assign active_dir_o = r_dir;

endmodule

// File: tb/tb_traffic_lights_multi.sv
// Scoreboard bench for traffic_lights_multi: a 2-approach and a 3-approach
// instance run side by side. Stimulus pushes the expected lamp vector for
// each cycle; a monitor pops and compares on the falling edge.
module tb_traffic_lights_multi;

   typedef struct {
      string      tag;
      logic [7:0] r;
      logic [7:0] y;
      logic [7:0] g;
      logic [2:0] dir;
   } exp_t;

   logic clk;
   int   n_vec;
   int   n_err;
   exp_t q2[$];
   exp_t q3[$];

   logic       srst2, c2_valid;
   logic [2:0] c2_type;
   logic [0:0] c2_dir;
   logic [15:0] c2_data;
   logic [1:0] red2, yel2, grn2;
   logic [0:0] dir2;

   logic       srst3, c3_valid;
   logic [2:0] c3_type;
   logic [1:0] c3_dir;
   logic [15:0] c3_data;
   logic [2:0] red3, yel3, grn3;
   logic [1:0] dir3;

   traffic_lights_multi #(
      .NUM_DIR(2), .CLK_PER_MS(2), .TIME_W(16), .RED_YEL_MS(50),
      .GREEN_BLINK_MS(50), .BLINK_HALF_MS(5), .DEF_GREEN_MS(500),
      .DEF_YELLOW_MS(100), .DEF_CLEAR_MS(20)
   ) u_dut2 (
      .clk_i(clk), .srst_i(srst2), .cmd_valid_i(c2_valid), .cmd_type_i(c2_type),
      .cmd_dir_i(c2_dir), .cmd_data_i(c2_data), .red_o(red2), .yellow_o(yel2),
      .green_o(grn2), .active_dir_o(dir2)
   );

   traffic_lights_multi #(
      .NUM_DIR(3), .CLK_PER_MS(2), .TIME_W(16), .RED_YEL_MS(50),
      .GREEN_BLINK_MS(50), .BLINK_HALF_MS(5), .DEF_GREEN_MS(500),
      .DEF_YELLOW_MS(100), .DEF_CLEAR_MS(20)
   ) u_dut3 (
      .clk_i(clk), .srst_i(srst3), .cmd_valid_i(c3_valid), .cmd_type_i(c3_type),
      .cmd_dir_i(c3_dir), .cmd_data_i(c3_data), .red_o(red3), .yellow_o(yel3),
      .green_o(grn3), .active_dir_o(dir3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Push n expected vectors, one per cycle, for instance 'which'.
   task automatic span(input int which, input int n, input string tag,
                       input logic [7:0] r, input logic [7:0] y,
                       input logic [7:0] g, input logic [2:0] d);
      exp_t e;
      e.tag = tag; e.r = r; e.y = y; e.g = g; e.dir = d;
      for (int i = 0; i < n; i++) begin
         if (which == 2) q2.push_back(e);
         else            q3.push_back(e);
         @(posedge clk); #1;
      end
   endtask

   task automatic cmd2(input logic [2:0] t, input logic [0:0] d, input logic [15:0] data,
                       input string tag, input logic [7:0] r, input logic [7:0] y,
                       input logic [7:0] g, input logic [2:0] ad);
      c2_valid = 1'b1; c2_type = t; c2_dir = d; c2_data = data;
      span(2, 1, tag, r, y, g, ad);
      c2_valid = 1'b0;
   endtask

   task automatic cmd3(input logic [2:0] t, input logic [1:0] d, input logic [15:0] data,
                       input string tag, input logic [7:0] r, input logic [7:0] y,
                       input logic [7:0] g, input logic [2:0] ad);
      c3_valid = 1'b1; c3_type = t; c3_dir = d; c3_data = data;
      span(3, 1, tag, r, y, g, ad);
      c3_valid = 1'b0;
   endtask

   task automatic run2();
      srst2 = 1'b1; c2_valid = 1'b0; c2_type = '0; c2_dir = '0; c2_data = '0;
      @(posedge clk); #1;
      span(2, 2, "rst", 8'h3, 8'h0, 8'h0, 3'd0);
      srst2 = 1'b0;
      span(2, 40, "ar0", 8'h3, 8'h0, 8'h0, 3'd0);
      span(2, 100, "ry0", 8'h3, 8'h1, 8'h0, 3'd0);
      span(2, 10, "g0", 8'h2, 8'h0, 8'h1, 3'd0);
      cmd2(3'd3, 1'b1, 16'd3, "g0", 8'h2, 8'h0, 8'h1, 3'd0);
      cmd2(3'd5, 1'b1, 16'd2, "g0", 8'h2, 8'h0, 8'h1, 3'd0);
      cmd2(3'd4, 1'b0, 16'd1, "g0", 8'h2, 8'h0, 8'h1, 3'd0);
      span(2, 987, "g0", 8'h2, 8'h0, 8'h1, 3'd0);
      for (int k = 0; k < 5; k++) begin
         span(2, 10, "gb0_lit", 8'h2, 8'h0, 8'h1, 3'd0);
         span(2, 10, "gb0_dark", 8'h2, 8'h0, 8'h0, 3'd0);
      end
      span(2, 200, "y0", 8'h2, 8'h1, 8'h0, 3'd0);
      span(2, 2, "ar1", 8'h3, 8'h0, 8'h0, 3'd1);
      span(2, 100, "ry1", 8'h3, 8'h2, 8'h0, 3'd1);
      span(2, 6, "g1", 8'h1, 8'h0, 8'h2, 3'd1);
      for (int k = 0; k < 5; k++) begin
         span(2, 10, "gb1_lit", 8'h1, 8'h0, 8'h2, 3'd1);
         span(2, 10, "gb1_dark", 8'h1, 8'h0, 8'h0, 3'd1);
      end
      span(2, 4, "y1", 8'h1, 8'h2, 8'h0, 3'd1);
      span(2, 2, "ar0_wrap", 8'h3, 8'h0, 8'h0, 3'd0);
      span(2, 100, "ry0", 8'h3, 8'h1, 8'h0, 3'd0);
      // FREE mode mid-green, then back to NORMAL
      span(2, 5, "g0", 8'h2, 8'h0, 8'h1, 3'd0);
      cmd2(3'd2, 1'b0, 16'd0, "g0", 8'h2, 8'h0, 8'h1, 3'd0);
      span(2, 10, "ba_lit", 8'h0, 8'h3, 8'h0, 3'd0);
      span(2, 10, "ba_dark", 8'h0, 8'h0, 8'h0, 3'd0);
      span(2, 10, "ba_lit", 8'h0, 8'h3, 8'h0, 3'd0);
      cmd2(3'd0, 1'b0, 16'd0, "ba_dark", 8'h0, 8'h0, 8'h0, 3'd0);
      span(2, 2, "ar0_norm", 8'h3, 8'h0, 8'h0, 3'd0);
      span(2, 100, "ry0", 8'h3, 8'h1, 8'h0, 3'd0);
      // OFF in the same cycle as the green timeout
      span(2, 999, "g0", 8'h2, 8'h0, 8'h1, 3'd0);
      cmd2(3'd1, 1'b0, 16'd0, "g0_last", 8'h2, 8'h0, 8'h1, 3'd0);
      span(2, 3, "dark", 8'h0, 8'h0, 8'h0, 3'd0);
      cmd2(3'd3, 1'b0, 16'd0, "dark", 8'h0, 8'h0, 8'h0, 3'd0);
      cmd2(3'd5, 1'b0, 16'd7, "dark", 8'h0, 8'h0, 8'h0, 3'd0);
      span(2, 3, "dark", 8'h0, 8'h0, 8'h0, 3'd0);
      cmd2(3'd0, 1'b0, 16'd0, "dark", 8'h0, 8'h0, 8'h0, 3'd0);
      span(2, 2, "ar0_norm", 8'h3, 8'h0, 8'h0, 3'd0);
      span(2, 100, "ry0", 8'h3, 8'h1, 8'h0, 3'd0);
      span(2, 2, "g0_zero", 8'h2, 8'h0, 8'h1, 3'd0);
      for (int k = 0; k < 5; k++) begin
         span(2, 10, "gb0_lit", 8'h2, 8'h0, 8'h1, 3'd0);
         span(2, 10, "gb0_dark", 8'h2, 8'h0, 8'h0, 3'd0);
      end
      span(2, 14, "y0_prog", 8'h2, 8'h1, 8'h0, 3'd0);
      span(2, 2, "ar1", 8'h3, 8'h0, 8'h0, 3'd1);
      span(2, 50, "ry1", 8'h3, 8'h2, 8'h0, 3'd1);
      cmd2(3'd2, 1'b0, 16'd0, "ry1", 8'h3, 8'h2, 8'h0, 3'd1);
      span(2, 7, "ba_lit", 8'h0, 8'h3, 8'h0, 3'd1);
      // one-cycle reset during blink
      srst2 = 1'b1;
      span(2, 1, "ba_lit", 8'h0, 8'h3, 8'h0, 3'd1);
      srst2 = 1'b0;
      span(2, 40, "rst_ar0", 8'h3, 8'h0, 8'h0, 3'd0);
      span(2, 100, "rst_ry0", 8'h3, 8'h1, 8'h0, 3'd0);
      span(2, 1000, "rst_g0", 8'h2, 8'h0, 8'h1, 3'd0);
      span(2, 10, "rst_gb0", 8'h2, 8'h0, 8'h1, 3'd0);
   endtask

   task automatic run3();
      logic [7:0] b, o;
      srst3 = 1'b1; c3_valid = 1'b0; c3_type = '0; c3_dir = '0; c3_data = '0;
      @(posedge clk); #1;
      span(3, 2, "rst3", 8'h7, 8'h0, 8'h0, 3'd0);
      srst3 = 1'b0;
      // per-approach writes to non-existent approach 3 must be dropped
      cmd3(3'd3, 2'd3, 16'd1, "ar3", 8'h7, 8'h0, 8'h0, 3'd0);
      cmd3(3'd5, 2'd3, 16'd1, "ar3", 8'h7, 8'h0, 8'h0, 3'd0);
      span(3, 38, "ar3", 8'h7, 8'h0, 8'h0, 3'd0);
      for (int d = 0; d < 3; d++) begin
         b = 8'h1 << d;
         o = 8'h7 & ~b;
         if (d > 0) span(3, 40, "ar3", 8'h7, 8'h0, 8'h0, 3'(d));
         span(3, 100, "ry3", 8'h7, b, 8'h0, 3'(d));
         span(3, 1000, "g3", o, 8'h0, b, 3'(d));
         for (int k = 0; k < 5; k++) begin
            span(3, 10, "gb3_lit", o, 8'h0, b, 3'(d));
            span(3, 10, "gb3_dark", o, 8'h0, 8'h0, 3'(d));
         end
         span(3, 200, "y3", o, b, 8'h0, 3'(d));
      end
      span(3, 3, "ar3_wrap", 8'h7, 8'h0, 8'h0, 3'd0);
   endtask

   // Monitor: compare one expected vector per instance per cycle.
   always @(negedge clk) begin
      exp_t e;
      if (q2.size() > 0) begin
         e = q2.pop_front();
         n_vec++;
         if (8'(red2) !== e.r || 8'(yel2) !== e.y || 8'(grn2) !== e.g || 3'(dir2) !== e.dir) begin
            n_err++;
            $display("FAIL dut2 %s @%0t: got r=%h y=%h g=%h dir=%0d, expected r=%h y=%h g=%h dir=%0d",
                     e.tag, $time, red2, yel2, grn2, dir2, e.r, e.y, e.g, e.dir);
         end
      end
      if (q3.size() > 0) begin
         e = q3.pop_front();
         n_vec++;
         if (8'(red3) !== e.r || 8'(yel3) !== e.y || 8'(grn3) !== e.g || 3'(dir3) !== e.dir) begin
            n_err++;
            $display("FAIL dut3 %s @%0t: got r=%h y=%h g=%h dir=%0d, expected r=%h y=%h g=%h dir=%0d",
                     e.tag, $time, red3, yel3, grn3, dir3, e.r, e.y, e.g, e.dir);
         end
      end
   end

   initial begin
      n_vec = 0;
      n_err = 0;
      fork
         run2();
         run3();
      join
      @(posedge clk);
      @(posedge clk);
      if (q2.size() + q3.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d vectors left unchecked, expected 0", q2.size() + q3.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      n_err++;
      $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
